// File: rtl/pp_pipeline_accel_axi2stream_row_sched.sv
// pp_pipeline_accel_axi2stream_row_sched
//   Row scheduler for the gmem1 -> ldata reader loop of the Axi2AxiStream
//   stage. For every image row it starts the reader loop with the row's beat
//   bound, issues the gmem1 AR bursts the loop will consume, throttles the
//   number of outstanding bursts by counting R handshakes tapped from the
//   loop, and waits for the loop's done before moving to the next row.
//
// Ports
//   ap_clk, ap_rst (async, active high)
//   ap_start/ap_done/ap_ready/ap_idle    : block-level handshake
//   base_addr/rows/cols_beats/stride_bytes : frame config, latched at start
//   m_axi_gmem1_AR{VALID,READY,ADDR,LEN} : read-address channel (LEN = beats)
//   r_beat                               : RVALID & RREADY tap from the loop
//   loop_ap_start/loop_ap_done           : reader-loop handshake
//   loop_cols_addrbound                  : loop iteration bound
//
// Build option
//   PP_ROW_SCHED_4K_SPLIT_EN : also split bursts at 4 KiB address boundaries.

module pp_pipeline_accel_axi2stream_row_sched #(
  parameter int MAX_BURST       = 256,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic        ap_clk,
  input  logic        ap_rst,
  input  logic        ap_start,
  output logic        ap_done,
  output logic        ap_ready,
  output logic        ap_idle,
  input  logic [63:0] base_addr,
  input  logic [15:0] rows,
  input  logic [20:0] cols_beats,
  input  logic [31:0] stride_bytes,
  output logic        m_axi_gmem1_ARVALID,
  input  logic        m_axi_gmem1_ARREADY,
  output logic [63:0] m_axi_gmem1_ARADDR,
  output logic [31:0] m_axi_gmem1_ARLEN,
  input  logic        r_beat,
  output logic        loop_ap_start,
  input  logic        loop_ap_done,
  output logic [20:0] loop_cols_addrbound
);

  localparam int PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

  typedef enum logic [1:0] {S_IDLE, S_ROW, S_WAIT_LOOP, S_DONE} state_t;
  state_t state, state_nxt;

  logic [63:0] row_addr, chunk_addr;
  logic [15:0] rows_q, row_idx;
  logic [20:0] cols_q, rem, arlen_c;
  logic [31:0] stride_q;
  logic        loop_start_q, pend_done, degen;
  logic [3:0]  outstanding;
  logic [8:0]  beat_cnt;
  logic [8:0]  fifo_mem [2**PW];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic        ar_hs, retire, row_last, done_evt, start_degen;

  // Burst length: capped by MAX_BURST and the remaining beats of the row.
  always_comb begin
    arlen_c = (rem > 21'(MAX_BURST)) ? 21'(MAX_BURST) : rem;
`ifdef PP_ROW_SCHED_4K_SPLIT_EN
    begin : page_cap
      logic [20:0] page_beats;
      // chunk_addr is 8-byte aligned, so this is 1..512 beats to the page end
      page_beats = 21'((13'd4096 - {1'b0, chunk_addr[11:0]}) >> 3);
      if (page_beats < arlen_c) arlen_c = page_beats;
    end
`endif
  end

  assign m_axi_gmem1_ARVALID = (state == S_ROW) && (rem != 21'd0) &&
                               (outstanding < 4'(MAX_OUTSTANDING));
  assign m_axi_gmem1_ARADDR  = chunk_addr;
  assign m_axi_gmem1_ARLEN   = {11'd0, arlen_c};
  assign ar_hs               = m_axi_gmem1_ARVALID && m_axi_gmem1_ARREADY;

  // Retire on the beat that completes the oldest burst, so a throttled AR
  // can go out the very next cycle.
  assign retire = (outstanding != 4'd0) && r_beat &&
                  ((beat_cnt + 9'd1) == fifo_mem[rd_ptr]);

  assign done_evt    = loop_ap_done || pend_done;
  assign row_last    = (row_idx == rows_q - 16'd1);
  assign start_degen = (rows == 16'd0) || (cols_beats == 21'd0);

  assign ap_idle             = (state == S_IDLE);
  // Degenerate frames spend one extra DONE cycle (degen set) before the pulse.
  assign ap_done             = (state == S_DONE) && !degen;
  assign ap_ready            = ap_done;
  assign loop_ap_start       = loop_start_q;
  assign loop_cols_addrbound = cols_q;

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:      if (ap_start) state_nxt = start_degen ? S_DONE : S_ROW;
      S_ROW:       if (ar_hs && (rem == arlen_c)) state_nxt = S_WAIT_LOOP;
      S_WAIT_LOOP: if (done_evt) state_nxt = row_last ? S_DONE : S_ROW;
      S_DONE:      if (!degen) state_nxt = S_IDLE;
      default:     state_nxt = S_IDLE;
    endcase
  end

  // Row / chunk datapath. rem and chunk_addr are loaded on entry to ROW so the
  // first ROW cycle can already present a valid AR.
  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      rows_q       <= '0;
      cols_q       <= '0;
      stride_q     <= '0;
      row_addr     <= '0;
      row_idx      <= '0;
      chunk_addr   <= '0;
      rem          <= '0;
      loop_start_q <= 1'b0;
      pend_done    <= 1'b0;
      degen        <= 1'b0;
    end else begin
      loop_start_q <= 1'b0;
      case (state)
        S_IDLE: if (ap_start) begin
          rows_q       <= rows;
          cols_q       <= cols_beats;
          stride_q     <= stride_bytes;
          row_addr     <= base_addr;
          chunk_addr   <= base_addr;
          row_idx      <= '0;
          rem          <= start_degen ? 21'd0 : cols_beats;
          degen        <= start_degen;
          loop_start_q <= !start_degen;
          pend_done    <= 1'b0;
        end
        S_ROW: begin
          if (ar_hs) begin
            rem        <= rem - arlen_c;
            chunk_addr <= chunk_addr + {40'd0, arlen_c, 3'b000};
          end
          // The loop may finish before the last AR handshake.
          if (loop_ap_done) pend_done <= 1'b1;
        end
        S_WAIT_LOOP: if (done_evt) begin
          pend_done <= 1'b0;
          if (!row_last) begin
            row_idx      <= row_idx + 16'd1;
            row_addr     <= row_addr + {32'd0, stride_q};
            chunk_addr   <= row_addr + {32'd0, stride_q};
            rem          <= cols_q;
            loop_start_q <= 1'b1;
          end
        end
        S_DONE: degen <= 1'b0;
        default: ;
      endcase
    end
  end

  // Outstanding-burst accounting: FIFO of issued lengths, oldest first.
  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      beat_cnt    <= '0;
      outstanding <= '0;
      for (int i = 0; i < 2**PW; i++) fifo_mem[i] <= '0;
    end else begin
      if (ar_hs) begin
        fifo_mem[wr_ptr] <= arlen_c[8:0];
        wr_ptr <= (wr_ptr == PW'(MAX_OUTSTANDING - 1)) ? '0 : wr_ptr + 1'b1;
      end
      if (retire) begin
        rd_ptr   <= (rd_ptr == PW'(MAX_OUTSTANDING - 1)) ? '0 : rd_ptr + 1'b1;
        beat_cnt <= '0;
      end else if (r_beat && (outstanding != 4'd0)) begin
        beat_cnt <= beat_cnt + 9'd1;
      end
      case ({ar_hs, retire})
        2'b10:   outstanding <= outstanding + 4'd1;
        2'b01:   outstanding <= outstanding - 4'd1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_pp_pipeline_accel_axi2stream_row_sched.sv
module tb_pp_pipeline_accel_axi2stream_row_sched;

  logic        ap_clk = 1'b0;
  logic        ap_rst;
  logic        ap_start;
  logic        ap_done, ap_ready, ap_idle;
  logic [63:0] base_addr;
  logic [15:0] rows;
  logic [20:0] cols_beats;
  logic [31:0] stride_bytes;
  logic        arvalid, arready;
  logic [63:0] araddr;
  logic [31:0] arlen;
  logic        r_beat;
  logic        loop_ap_start, loop_ap_done;
  logic [20:0] loop_cols_addrbound;

  int checks = 0;
  int errors = 0;

  // handshake logs kept by the monitor
  logic [63:0] ar_addr_log [64];
  logic [31:0] ar_len_log  [64];
  int ar_cnt = 0;
  int ls_cnt = 0;
  int a0, l0;
  logic [63:0] hold_addr;
  logic [31:0] hold_len;

  always #5 ap_clk = ~ap_clk;

  pp_pipeline_accel_axi2stream_row_sched #(
    .MAX_BURST(256),
    .MAX_OUTSTANDING(2)
  ) dut (
    .ap_clk(ap_clk),
    .ap_rst(ap_rst),
    .ap_start(ap_start),
    .ap_done(ap_done),
    .ap_ready(ap_ready),
    .ap_idle(ap_idle),
    .base_addr(base_addr),
    .rows(rows),
    .cols_beats(cols_beats),
    .stride_bytes(stride_bytes),
    .m_axi_gmem1_ARVALID(arvalid),
    .m_axi_gmem1_ARREADY(arready),
    .m_axi_gmem1_ARADDR(araddr),
    .m_axi_gmem1_ARLEN(arlen),
    .r_beat(r_beat),
    .loop_ap_start(loop_ap_start),
    .loop_ap_done(loop_ap_done),
    .loop_cols_addrbound(loop_cols_addrbound)
  );

  always @(posedge ap_clk) begin
    if (!ap_rst) begin
      if (arvalid && arready && ar_cnt < 64) begin
        ar_addr_log[ar_cnt] = araddr;
        ar_len_log[ar_cnt]  = arlen;
        ar_cnt = ar_cnt + 1;
      end
      if (loop_ap_start) ls_cnt = ls_cnt + 1;
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge ap_clk);
    #1;
  endtask

  task automatic do_reset();
    ap_rst = 1'b1; ap_start = 1'b0; arready = 1'b0; r_beat = 1'b0; loop_ap_done = 1'b0;
    tick(); tick();
    ap_rst = 1'b0;
  endtask

  task automatic beats(input int n);
    r_beat = 1'b1;
    repeat (n) tick();
    r_beat = 1'b0;
  endtask

  task automatic pulse_loop_done();
    loop_ap_done = 1'b1;
    tick();
    loop_ap_done = 1'b0;
  endtask

  initial begin
    base_addr = '0; rows = '0; cols_beats = '0; stride_bytes = '0;
    do_reset();

    // ---- reset state
    check("rst_idle", ap_idle, 1);
    check("rst_done", ap_done, 0);
    check("rst_ready", ap_ready, 0);
    check("rst_arvalid", arvalid, 0);
    check("rst_araddr", araddr, 0);
    check("rst_arlen", arlen, 0);
    check("rst_loopstart", loop_ap_start, 0);
    check("rst_bound", loop_cols_addrbound, 0);

    // ---- single row, 600 beats, outstanding limit 2
    a0 = ar_cnt; l0 = ls_cnt;
    base_addr = 64'h1000; rows = 16'd1; cols_beats = 21'd600; stride_bytes = 32'd0;
    arready = 1'b1; ap_start = 1'b1;
    tick();                                    // cycle 1
    ap_start = 1'b0;
    check("t1_arvalid_c1", arvalid, 1);
    check("t1_loopstart_c1", loop_ap_start, 1);
    check("t1_idle_c1", ap_idle, 0);
    check("t1_bound", loop_cols_addrbound, 600);
    check("t1_addr0", araddr, 64'h1000);
    check("t1_len0", arlen, 256);
    tick();                                    // burst 0 accepted
    check("t1_loopstart_once", loop_ap_start, 0);
    tick();                                    // burst 1 accepted, limit hit
    check("t1_throttled", arvalid, 0);
    beats(255);
    check("t1_still_throttled", arvalid, 0);
    beats(1);                                  // 256th beat retires burst 0
    check("t1_third_valid", arvalid, 1);
    check("t1_third_addr", araddr, 64'h2000);
    check("t1_third_len", arlen, 88);
    tick();                                    // burst 2 accepted -> WAIT_LOOP
    check("t1_no_more_ar", arvalid, 0);
    beats(344);
    pulse_loop_done();
    check("t1_ap_done", ap_done, 1);
    check("t1_ap_ready", ap_ready, 1);
    tick();
    check("t1_done_pulse", ap_done, 0);
    check("t1_back_idle", ap_idle, 1);
    check("t1_ar_count", ar_cnt - a0, 3);
    check("t1_ar1_addr", ar_addr_log[a0+1], 64'h1800);
    check("t1_ar1_len", ar_len_log[a0+1], 256);
    check("t1_ar2_addr", ar_addr_log[a0+2], 64'h2000);
    check("t1_ar2_len", ar_len_log[a0+2], 88);
    check("t1_loop_starts", ls_cnt - l0, 1);

    // ---- multi-row stride
    do_reset();
    a0 = ar_cnt; l0 = ls_cnt;
    base_addr = 64'h10000; rows = 16'd3; cols_beats = 21'd16; stride_bytes = 32'h2000;
    arready = 1'b1; ap_start = 1'b1;
    tick();
    ap_start = 1'b0;
    for (int r = 0; r < 3; r++) begin
      check("t2_row_arvalid", arvalid, 1);
      check("t2_row_loopstart", loop_ap_start, 1);
      check("t2_row_addr", araddr, 64'h10000 + 64'h2000 * r);
      check("t2_row_len", arlen, 16);
      tick();
      beats(16);
      pulse_loop_done();
    end
    check("t2_ap_done", ap_done, 1);
    check("t2_ar_count", ar_cnt - a0, 3);
    check("t2_ar2_addr", ar_addr_log[a0+2], 64'h14000);
    check("t2_loop_starts", ls_cnt - l0, 3);
    tick();

    // ---- degenerate frames
    do_reset();
    a0 = ar_cnt; l0 = ls_cnt;
    rows = 16'd0; cols_beats = 21'd5; ap_start = 1'b1;
    tick();
    ap_start = 1'b0;
    check("t3_c1_done", ap_done, 0);
    check("t3_c1_arvalid", arvalid, 0);
    tick();
    check("t3_c2_done", ap_done, 1);
    tick();
    check("t3_idle", ap_idle, 1);
    rows = 16'd2; cols_beats = 21'd0; ap_start = 1'b1;
    tick();
    ap_start = 1'b0;
    check("t3b_c1_done", ap_done, 0);
    check("t3b_c1_loopstart", loop_ap_start, 0);
    tick();
    check("t3b_c2_done", ap_done, 1);
    tick();
    check("t3_no_ar", ar_cnt - a0, 0);
    check("t3_no_loopstart", ls_cnt - l0, 0);

    // ---- backpressure, early loop done, mid-row reset
    do_reset();
    base_addr = 64'h4000; rows = 16'd2; cols_beats = 21'd8; stride_bytes = 32'h100;
    arready = 1'b0; ap_start = 1'b1;
    tick();
    ap_start = 1'b0;
    hold_addr = araddr; hold_len = arlen;
    check("t4_hold_addr0", hold_addr, 64'h4000);
    check("t4_hold_len0", hold_len, 8);
    for (int c = 0; c < 10; c++) begin
      loop_ap_done = (c == 3);                 // loop finishes before AR accepted
      tick();
      check("t4_valid_stable", arvalid, 1);
      check("t4_addr_stable", araddr, hold_addr);
      check("t4_len_stable", arlen, hold_len);
    end
    loop_ap_done = 1'b0;
    arready = 1'b1;
    tick();                                    // accepted -> WAIT_LOOP, pending done
    check("t4_wait_no_ar", arvalid, 0);
    arready = 1'b0;
    tick();                                    // pending done consumed -> row 1
    check("t4_row1_valid", arvalid, 1);
    check("t4_row1_addr", araddr, 64'h4100);
    check("t4_row1_loopstart", loop_ap_start, 1);
    ap_rst = 1'b1;
    #1;
    check("t4_rst_arvalid", arvalid, 0);
    check("t4_rst_araddr", araddr, 0);
    check("t4_rst_arlen", arlen, 0);
    check("t4_rst_loopstart", loop_ap_start, 0);
    check("t4_rst_idle", ap_idle, 1);
    check("t4_rst_done", ap_done, 0);
    check("t4_rst_bound", loop_cols_addrbound, 0);
    tick();
    ap_rst = 1'b0;

    // ---- 4 KiB boundary handling
    do_reset();
    base_addr = 64'hF80; rows = 16'd1; cols_beats = 21'd64; stride_bytes = 32'd0;
    arready = 1'b1; ap_start = 1'b1;
    tick();
    ap_start = 1'b0;
    check("t5_addr0", araddr, 64'hF80);
`ifdef PP_ROW_SCHED_4K_SPLIT_EN
    check("t5_len0", arlen, 16);
    tick();
    check("t5_addr1", araddr, 64'h1000);
    check("t5_len1", arlen, 48);
    check("t5_valid1", arvalid, 1);
`else
    check("t5_len0", arlen, 64);
    tick();
    check("t5_single_burst", arvalid, 0);
`endif
    do_reset();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
